branch_resolve_unit: RTL

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit_pkg.sv | 38 +++
 rtl/branch_resolve_unit_compare.sv | 33 +++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolution unit: branch
// condition encodings, controller states and statistics counter helpers.
package branch_resolve_unit_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } brs_state_e;

  // Only the six conditional-branch encodings resolve; 010/011 are not branches.
  function automatic logic is_branch_f3(input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition evaluator (funct3, rs1, rs2 -> taken).
module branch_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  // Evaluate the condition; non-branch encodings report not-taken.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = (rs1_s <  rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates the branch condition, reports the
// actual outcome to the predictor, redirects fetch on a mispredict and holds
// flush for FLUSH_CYCLES cycles while wrong-path instructions drain.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clkFSM,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1_val,
  input  logic [XLEN-1:0]  ex_rs2_val,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             result,
  output logic             result_valid,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  // Flush counter is loaded with the number of extra cycles after the first.
  localparam logic [2:0]      FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  brs_state_e       state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic             result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic             taken;
  logic             resolvable;
  logic             mispredict;
  logic [XLEN-1:0]  target_pc;

  branch_compare #(
    .XLEN (XLEN)
  ) u_compare (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1_val),
    .rs2    (ex_rs2_val),
    .taken  (taken)
  );

  // Qualify the EX instruction and form the corrected fetch address.
  always_comb begin
    resolvable = (state_q == ST_IDLE) & ex_valid & ex_is_branch & is_branch_f3(ex_funct3);
    mispredict = resolvable & (taken != ex_pred_taken);
    target_pc  = taken ? (ex_pc + ex_imm) : (ex_pc + PC_STEP);
  end

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    result_d         = result_q;
    result_valid_d   = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (resolvable) begin
          result_d       = taken;
          result_valid_d = 1'b1;
          branch_cnt_d   = sat_inc(branch_cnt_q);
          if (mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target_pc;
            mispredict_cnt_d = sat_inc(mispredict_cnt_q);
            flush_d          = 1'b1;
            flush_cnt_d      = FLUSH_LAST;
            state_d          = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // EX contents are wrong-path here and are deliberately ignored.
        if (flush_cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          flush_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset clears everything, even mid-flush.
  always_ff @(posedge clkFSM or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= 3'd0;
      result_q         <= 1'b0;
      result_valid_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      result_q         <= result_d;
      result_valid_q   <= result_valid_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign result         = result_q;
  assign result_valid   = result_valid_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
